vga_timing_gen: RTL

Raster timing generator for the 640x480@60 VGA path. Produces horizontal/vertical position counters, sync pulses and an active-video flag, all registered and mutually coherent. Sits directly upstream of the pixel-pattern and colour stages: they consume `h_cnt`/`v_cnt`/`active` to choose RGB and forward `h_sync`/`v_sync` to the connector with matching pipeline delay.

---
 rtl/vga_pkg.sv | 24 ++
 rtl/vga_timing_gen_if.sv | 23 ++
 rtl/vga_axis_cnt.sv | 58 +++++
 rtl/vga_timing_gen.sv | 93 +++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants and the axis-length helper used by the
// timing generator and its per-axis counters.
package vga_pkg;

  localparam int CNT_W = 10;

  localparam int VGA_H_VIZ   = 640;
  localparam int VGA_H_FP    = 16;
  localparam int VGA_H_PULSE = 96;
  localparam int VGA_H_BP    = 48;

  localparam int VGA_V_VIZ   = 480;
  localparam int VGA_V_FP    = 10;
  localparam int VGA_V_PULSE = 2;
  localparam int VGA_V_BP    = 33;

  function automatic int axis_total(int viz, int fp, int pulse, int bp);
    return viz + fp + pulse + bp;
  endfunction

  localparam int VGA_H_TOTAL = axis_total(VGA_H_VIZ, VGA_H_FP, VGA_H_PULSE, VGA_H_BP);
  localparam int VGA_V_TOTAL = axis_total(VGA_V_VIZ, VGA_V_FP, VGA_V_PULSE, VGA_V_BP);

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: the generator (master) drives positions and flags,
// the consuming pixel pipeline (slave) supplies the advance enable.
interface vga_timing_gen_if;
  logic                      en;
  logic                      pix_ce;
  logic [vga_pkg::CNT_W-1:0] h_cnt;
  logic [vga_pkg::CNT_W-1:0] v_cnt;
  logic                      h_sync;
  logic                      v_sync;
  logic                      active;
  logic                      line_start;
  logic                      frame_start;

  modport master (
    input  en,
    output pix_ce, h_cnt, v_cnt, h_sync, v_sync, active, line_start, frame_start
  );

  modport slave (
    output en,
    input  pix_ce, h_cnt, v_cnt, h_sync, v_sync, active, line_start, frame_start
  );
endinterface

// File: rtl/vga_axis_cnt.sv
// One raster axis: wrapping position counter with terminal count, plus sync
// and visible decode taken from the next count so flags align with cnt.
module vga_axis_cnt
  import vga_pkg::*;
#(
  parameter int VIZ      = VGA_H_VIZ,
  parameter int FP       = VGA_H_FP,
  parameter int PULSE    = VGA_H_PULSE,
  parameter int BP       = VGA_H_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  output logic [CNT_W-1:0] cnt,
  output logic             tc,
  output logic             sync,
  output logic             viz_nxt
);

  localparam int TOTAL = axis_total(VIZ, FP, PULSE, BP);

  if (TOTAL > (1 << CNT_W)) begin : g_total_chk
    $error("vga_axis_cnt: axis total %0d exceeds counter range", TOTAL);
  end

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(VIZ + FP);
  localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(VIZ + FP + PULSE);
  localparam logic [CNT_W-1:0] VIZ_N   = CNT_W'(VIZ);

  logic [CNT_W-1:0] cnt_nxt;
  logic             sync_on_nxt;

  assign tc = (cnt == LAST);

  always_comb begin
    cnt_nxt = cnt;
    if (step) begin
      cnt_nxt = tc ? '0 : cnt + 1'b1;
    end
  end

  assign viz_nxt     = (cnt_nxt < VIZ_N);
  assign sync_on_nxt = (cnt_nxt >= SYNC_LO) && (cnt_nxt < SYNC_HI);

  // Reset parks on the last position so the first step lands on 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= LAST;
      sync <= ~SYNC_POL;
    end else if (step) begin
      cnt  <= cnt_nxt;
      sync <= sync_on_nxt ? SYNC_POL : ~SYNC_POL;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing generator. Define VGA_TIMING_CE_DIV2_EN to run from
// a 2x clock with an internal divide-by-two pixel clock-enable.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VIZ    = VGA_H_VIZ,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_PULSE  = VGA_H_PULSE,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_VIZ    = VGA_V_VIZ,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_PULSE  = VGA_V_PULSE,
  parameter int V_BP     = VGA_V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input logic               clk,
  input logic               rst,
  vga_timing_gen_if.master  vif
);

  logic             pix_ce;
  logic             step;
  logic             h_tc, v_tc;
  logic             h_viz_nxt, v_viz_nxt;
  logic             h_sync, v_sync;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             active_q, line_start_q, frame_start_q;

`ifdef VGA_TIMING_CE_DIV2_EN
  logic ce_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ce_q <= 1'b0;
    end else if (vif.en) begin
      ce_q <= ~ce_q;
    end
  end

  assign pix_ce = ce_q;
`else
  assign pix_ce = 1'b1;
`endif

  assign step = vif.en & pix_ce;

  vga_axis_cnt #(
    .VIZ(H_VIZ), .FP(H_FP), .PULSE(H_PULSE), .BP(H_BP), .SYNC_POL(SYNC_POL)
  ) u_h (
    .clk     (clk),
    .rst     (rst),
    .step    (step),
    .cnt     (h_cnt),
    .tc      (h_tc),
    .sync    (h_sync),
    .viz_nxt (h_viz_nxt)
  );

  vga_axis_cnt #(
    .VIZ(V_VIZ), .FP(V_FP), .PULSE(V_PULSE), .BP(V_BP), .SYNC_POL(SYNC_POL)
  ) u_v (
    .clk     (clk),
    .rst     (rst),
    .step    (step & h_tc),
    .cnt     (v_cnt),
    .tc      (v_tc),
    .sync    (v_sync),
    .viz_nxt (v_viz_nxt)
  );

  // Wrapping from the terminal count is exactly "next position is 0".
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (step) begin
      active_q      <= h_viz_nxt & v_viz_nxt;
      line_start_q  <= h_tc;
      frame_start_q <= h_tc & v_tc;
    end
  end

  assign vif.pix_ce      = pix_ce;
  assign vif.h_cnt       = h_cnt;
  assign vif.v_cnt       = v_cnt;
  assign vif.h_sync      = h_sync;
  assign vif.v_sync      = v_sync;
  assign vif.active      = active_q;
  assign vif.line_start  = line_start_q;
  assign vif.frame_start = frame_start_q;

endmodule
